// File: rtl/alu_arbiter.sv
// Purpose : shares one registered-result ALU between the core issue port (req 0) and the
//           debug/loader port (req 1), returning ALU_result and the zero flag per requester.
// Latency : request accept to resp_valid = 3 cycles; one op in flight, 1 op per 4 cycles max.
// Backpressure: req_ready only in IDLE; RESP holds result/zero until resp_ready of the owner.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make req 0 win every simultaneous request
// (last_grant is then not built). Left undefined, ties alternate round-robin.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready is one-hot or zero)
//   req_aluop..req_imm       per-requester op fields, packed {r1,r0}
//   resp_valid/resp_ready    per-requester response handshake (valid is one-hot to owner)
//   resp_result, resp_zero   captured ALU result and zero flag
//   alu_*                    ALU controls/operands (all-zero in IDLE), alu_result/alu_zero back
//   busy                     high in any state other than IDLE
//   op_count                 completed responses, wraps modulo 2^CNT_W
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_aluop,
    input  logic [5:0]            req_funct3,
    input  logic [1:0]            req_funct7,
    input  logic [1:0]            req_alusrc,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [2*DATA_W-1:0]   req_imm,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_result,
    output logic                  resp_zero,
    output logic [1:0]            alu_aluop,
    output logic [2:0]            alu_funct3,
    output logic                  alu_funct7,
    output logic                  alu_alusrc,
    output logic [DATA_W-1:0]     alu_rd1,
    output logic [DATA_W-1:0]     alu_rd2,
    output logic [DATA_W-1:0]     alu_imm,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    logic               owner;
    logic [1:0]         grant;
    logic               accept;
    logic               sel;
    logic               resp_hs;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Index of the requester granted most recently; resets to 1 so req 0 wins the first tie.
    logic               last_grant;
`endif

    // Operand fields of the requester being granted this cycle.
    logic [1:0]         sel_aluop;
    logic [2:0]         sel_funct3;
    logic               sel_funct7;
    logic               sel_alusrc;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [DATA_W-1:0]  sel_imm;

    always_comb begin
        grant = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
`else
        if (&req_valid) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid;
        end
`endif
    end

    // Ready is offered only while idle and never while reset is asserted.
    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel       = grant[1];

    assign sel_aluop  = sel ? req_aluop[3:2]             : req_aluop[1:0];
    assign sel_funct3 = sel ? req_funct3[5:3]            : req_funct3[2:0];
    assign sel_funct7 = sel ? req_funct7[1]              : req_funct7[0];
    assign sel_alusrc = sel ? req_alusrc[1]              : req_alusrc[0];
    assign sel_a      = sel ? req_a[2*DATA_W-1:DATA_W]   : req_a[DATA_W-1:0];
    assign sel_b      = sel ? req_b[2*DATA_W-1:DATA_W]   : req_b[DATA_W-1:0];
    assign sel_imm    = sel ? req_imm[2*DATA_W-1:DATA_W] : req_imm[DATA_W-1:0];

    // Only the owner's resp_ready matters; resp_valid is already one-hot to the owner.
    assign resp_hs = |(resp_valid & resp_ready);

    // The alu_* outputs double as the latched copy of the granted op: loaded on accept,
    // held through ISSUE/CAPT/RESP, cleared when the response completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            busy        <= 1'b0;
            resp_valid  <= 2'b00;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            op_count    <= '0;
            alu_aluop   <= 2'b00;
            alu_funct3  <= 3'b000;
            alu_funct7  <= 1'b0;
            alu_alusrc  <= 1'b0;
            alu_rd1     <= '0;
            alu_rd2     <= '0;
            alu_imm     <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= sel;
                        busy       <= 1'b1;
                        alu_aluop  <= sel_aluop;
                        alu_funct3 <= sel_funct3;
                        alu_funct7 <= sel_funct7;
                        alu_alusrc <= sel_alusrc;
                        alu_rd1    <= sel_a;
                        alu_rd2    <= sel_b;
                        alu_imm    <= sel_imm;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= sel;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // alu_zero is combinational on the held operands; the ALU registers
                    // its result on this same edge.
                    resp_zero <= alu_zero;
                    state     <= CAPT;
                end
                CAPT: begin
                    resp_result <= alu_result;
                    resp_valid  <= owner ? 2'b10 : 2'b01;
                    state       <= RESP;
                end
                RESP: begin
                    // No grant is made in the handshake cycle: IDLE is entered first.
                    if (resp_hs) begin
                        resp_valid <= 2'b00;
                        op_count   <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy       <= 1'b0;
                        alu_aluop  <= 2'b00;
                        alu_funct3 <= 3'b000;
                        alu_funct7 <= 1'b0;
                        alu_alusrc <= 1'b0;
                        alu_rd1    <= '0;
                        alu_rd2    <= '0;
                        alu_imm    <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
